// File: rtl/fp_minmax_reduce_pkg.sv
// Shared FPU definitions: operation codes, canonical quiet NaN and the
// single-precision field positions used by the min/max datapath.
package fp_minmax_reduce_pkg;

    localparam logic OP_MIN = 1'b0;
    localparam logic OP_MAX = 1'b1;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    localparam int FP_SIGN_BIT = 31;
    localparam int FP_EXP_MSB  = 30;
    localparam int FP_EXP_LSB  = 23;
    localparam int FP_MAN_MSB  = 22;
    localparam int FP_MAN_LSB  = 0;

endpackage

// File: rtl/fp_minmax_reduce_if.sv
// Command, element stream and result signals of the min/max reduction engine.
// The master issues commands and elements; the slave is the reduction engine.
interface fp_minmax_reduce_if #(
    parameter int CNT_W = 8
) ();
    logic             start;
    logic             op;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic [31:0]      in_data;
    logic             in_ready;
    logic             out_valid;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] out_idx;
    logic             out_ready;
    logic             busy;

    modport master (
        output start, op, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, busy
    );

    modport slave (
        input  start, op, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, busy
    );
endinterface

// File: rtl/fp_minmax_reduce_cmp_sel.sv
// Combinational FP min/max selector. Orders raw bit patterns totally:
// sign first (+0 above -0), then magnitude, inverted for negatives.
// NaNs are ordered by their bits like any other value.
module fp_cmp_sel
    import fp_minmax_reduce_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op,
    output logic        take_b
);
    logic        a_sign;
    logic        b_sign;
    logic [30:0] a_mag;
    logic [30:0] b_mag;
    logic        a_gt_b;
    logic        b_gt_a;

    assign a_sign = a[FP_SIGN_BIT];
    assign b_sign = b[FP_SIGN_BIT];
    assign a_mag  = {a[FP_EXP_MSB:FP_EXP_LSB], a[FP_MAN_MSB:FP_MAN_LSB]};
    assign b_mag  = {b[FP_EXP_MSB:FP_EXP_LSB], b[FP_MAN_MSB:FP_MAN_LSB]};

    // Strict ordering in both directions; B is taken only on a strict win so
    // that ties keep the earlier element.
    always_comb begin
        a_gt_b = 1'b0;
        b_gt_a = 1'b0;
        take_b = 1'b0;
        if (a_sign != b_sign) begin
            a_gt_b = ~a_sign;
            b_gt_a = ~b_sign;
        end else if (!a_sign) begin
            a_gt_b = (a_mag > b_mag);
            b_gt_a = (b_mag > a_mag);
        end else begin
            a_gt_b = (a_mag < b_mag);
            b_gt_a = (b_mag < a_mag);
        end
        if (op == OP_MAX) begin
            take_b = b_gt_a;
        end else if (op == OP_MIN) begin
            take_b = a_gt_b;
        end
    end
endmodule

// File: rtl/fp_minmax_reduce.sv
// Vector min/max reduction sequencer: streams elements through fp_cmp_sel,
// tracking the running winner and its index, and holds the result on a
// valid/ready output until consumed.
module fp_minmax_reduce
    import fp_minmax_reduce_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input logic               clk,
    input logic               rst,
    fp_minmax_reduce_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRST,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t           state_reg,   state_next;
    logic [31:0]      acc_reg,     acc_next;
    logic [CNT_W-1:0] acc_idx_reg, acc_idx_next;
    logic [CNT_W-1:0] count_reg,   count_next;
    logic [CNT_W-1:0] len_reg,     len_next;
    logic             op_reg,      op_next;
    logic             take_b;

    fp_cmp_sel u_cmp (
        .a      (acc_reg),
        .b      (bus.in_data),
        .op     (op_reg),
        .take_b (take_b)
    );

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            acc_reg     <= '0;
            acc_idx_reg <= '0;
            count_reg   <= '0;
            len_reg     <= '0;
            op_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            acc_idx_reg <= acc_idx_next;
            count_reg   <= count_next;
            len_reg     <= len_next;
            op_reg      <= op_next;
        end
    end

    // Next-state and datapath update; in_valid low leaves everything as is.
    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        acc_idx_next = acc_idx_reg;
        count_next   = count_reg;
        len_next     = len_reg;
        op_next      = op_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    op_next    = bus.op;
                    len_next   = bus.len;
                    count_next = '0;
                    if (bus.len == '0) begin
                        // Empty vector reduces to the canonical quiet NaN.
                        acc_next     = FP_QNAN;
                        acc_idx_next = '0;
                        state_next   = S_DONE;
                    end else begin
                        state_next = S_FIRST;
                    end
                end
            end
            S_FIRST: begin
                if (bus.in_valid) begin
                    acc_next     = bus.in_data;
                    acc_idx_next = '0;
                    count_next   = CNT_W'(1);
                    state_next   = (len_reg == CNT_W'(1)) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (bus.in_valid) begin
                    if (take_b) begin
                        acc_next     = bus.in_data;
                        acc_idx_next = count_reg;
                    end
                    count_next = count_reg + CNT_W'(1);
                    if (count_reg == len_reg - CNT_W'(1)) begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_reg == S_FIRST) || (state_reg == S_ACCUM);
    assign bus.out_valid = (state_reg == S_DONE);
    assign bus.busy      = (state_reg != S_IDLE);
    assign bus.out_data  = acc_reg;
    assign bus.out_idx   = acc_idx_reg;
endmodule

// File: doc/fp_minmax_reduce.md
# fp_minmax_reduce

Sequencer that streams a vector of single-precision operands through a shared FP min/max comparator and returns the running minimum or maximum together with the index of the winning element. It sits beside the FPU as the reduction engine for vector min/max and for the fmin/fmax reduction pseudo-ops. A start command configures it, a valid/ready input stream feeds it at one element per cycle, and the result is held on a valid/ready output until it is consumed.

## Interface
- `CNT_W`, default 8: width of the length and index fields; maximum vector length is 2^CNT_W − 1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `op`  in  1  operation: 0 = min, 1 = max; latched on an accepted start.
- `len`  in  CNT_W  element count; latched on an accepted start.
- `in_valid`  in  1  input element valid.
- `in_data`  in  32  IEEE-754 single-precision element.
- `in_ready`  out  1  block accepts an element this cycle.
- `out_valid`  out  1  result valid.
- `out_data`  out  32  reduced value.
- `out_idx`  out  CNT_W  zero-based position of the winning element.
- `out_ready`  in  1  consumer accepts the result.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, FIRST, ACCUM, DONE.
- IDLE: `start`=1 latches `op` and `len`, and clears the element counter.
  - `len`=0 → DONE with `out_data`=0x7FC0_0000 and `out_idx`=0.
  - Otherwise → FIRST.
- FIRST: `in_ready`=1. On a handshake, acc←`in_data`, acc_idx←0, count←1. Then go to DONE if `len`=1, else to ACCUM.
- ACCUM: `in_ready`=1. On a handshake, the comparator evaluates acc (operand A) against `in_data` (operand B).
  - B replaces acc, and acc_idx←count, only if B is strictly less (min) or strictly greater (max).
  - count increments on every handshake.
  - When the handshake consumes element `len`−1 → DONE.
- DONE: `out_valid`=1, with `out_data`=acc and `out_idx`=acc_idx held stable. On `out_valid`&`out_ready` → IDLE.
- Ordering is a total order on raw bit patterns:
  - The sign bit decides first; +0 > −0.
  - Same sign: compare {exponent, mantissa} as an unsigned number. A larger magnitude is greater for positive operands and smaller for negative operands.
  - NaNs get no special treatment; they order by bit pattern.
- Ties (bit-identical operands) keep the earlier element, so the lowest index wins.
- `start` outside IDLE is ignored; `op` and `len` do not change mid-vector.
- `in_valid` low stalls the sequencer with no state change. Throughput is one element per cycle.

## Timing
- Reset values: state=IDLE; `in_ready`=0, `out_valid`=0, `busy`=0, `out_data`=0, `out_idx`=0; internal acc, count and latched len/op all 0.
- Reset asserted in any state, including mid-vector or in DONE with `out_valid` high, returns the block to IDLE on that edge. The partial result is discarded.
- The cycle after an accepted `start`, `busy`=1 and `in_ready`=1 (for `len` ≥ 1).
- `out_valid` rises on the cycle after the last input handshake. Minimum latency from start to `out_valid` is `len`+1 cycles.
- `in_ready` is a registered function of state only; it does not depend combinationally on `in_valid`. `in_ready` is 0 in IDLE and DONE.
- Back-to-back: `start` may be asserted in the cycle after the output handshake (the first IDLE cycle). A `start` asserted in the same cycle as the output handshake is ignored.
- The comparator path is combinational within one cycle: acc → compare → acc register.

## Structure
- Shared FPU package holds:
  - OP_MIN=1'b0 and OP_MAX=1'b1;
  - FP_QNAN=32'h7FC0_0000;
  - the field positions: sign bit 31, exponent [30:23], mantissa [22:0].
- The state enumeration is local to this block.
- One sub-module, `fp_cmp_sel`: a combinational comparator that takes A, B and `op` and outputs `take_b`. It is the shared datapath that this block sequences.

## Test plan
- Max over {0x3F80_0000 (1.0), 0xC000_0000 (−2.0), 0x4060_0000 (3.5), 0x3F00_0000 (0.5)} → `out_data`=0x4060_0000, `out_idx`=2, `out_valid` on the cycle after the 4th handshake.
- Same vector with `op`=0 (min), with `in_valid` dropped for 3 cycles after element 1 → `out_data`=0xC000_0000, `out_idx`=1; `in_ready` stays high and the count is unchanged during the stall.
- Min over {0x0000_0000, 0x8000_0000} → 0x8000_0000, idx 1. Max over {0x3F80_0000, 0x3F80_0000} → idx 0 (tie keeps the earlier element).
- `len`=0 → `out_valid` 1 cycle after start, with `out_data`=0x7FC0_0000 and `out_idx`=0. Hold `out_ready`=0 for 5 cycles → outputs stay stable; a `start` pulse during DONE is ignored.
- `rst` asserted after 2 of 4 elements → next cycle all outputs are at their reset values. A new start with `len`=1 and element 0xBF80_0000 → result 0xBF80_0000, idx 0.
